// File: rtl/vector_check_engine.sv
// Vector-driven self-checking engine: fetches stimulus/expected pairs, drives a DUT,
// waits SETTLE cycles and scores the response. Optional macro: VEC_CHECK_STOP_ON_FAIL_EN.
module vector_check_engine #(
  parameter int STIM_W    = 68,
  parameter int RESP_W    = 34,
  parameter int NUM_TESTS = 4,
  parameter int SETTLE    = 1,
  parameter int ADDR_W    = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  parameter int CNT_W     = $clog2(NUM_TESTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [STIM_W-1:0] mem_stim,
  input  logic [RESP_W-1:0] mem_exp,
  output logic [STIM_W-1:0] dut_stim,
  input  logic [RESP_W-1:0] dut_resp,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  score,
  output logic [CNT_W-1:0]  fail_count,
  output logic              first_fail_vld,
  output logic [ADDR_W-1:0] first_fail_idx
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [SW-1:0]     r_settle_cnt;
  logic [RESP_W-1:0] r_exp;
  logic [STIM_W-1:0] r_dut_stim;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_score;
  logic [CNT_W-1:0]  r_fail_count;
  logic              r_ff_vld;
  logic [ADDR_W-1:0] r_ff_idx;

  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] w_next_idx;
  logic              w_launch;
  logic              w_pass;
  logic              w_last;
  logic              w_stop;

  // An X/Z on the response makes the equality unknown, which falls into the fail branch.
  assign w_pass = (dut_resp == r_exp);
  assign w_last = (r_idx == ADDR_W'(NUM_TESTS - 1));

`ifdef VEC_CHECK_STOP_ON_FAIL_EN
  assign w_stop = ~w_pass;
`else
  assign w_stop = 1'b0;
`endif

  // Next-state and vector-index selection.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_next_idx   = {ADDR_W{1'b0}};
          w_launch     = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      S_FETCH:  w_next_state = S_APPLY;
      S_APPLY:  w_next_state = S_SETTLE;
      S_SETTLE: begin
        if (r_settle_cnt == SW'(SETTLE - 1)) begin
          w_next_state = S_CHECK;
        end else begin
          w_next_state = S_SETTLE;
        end
      end
      S_CHECK: begin
        if (w_last || w_stop) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_FETCH;
          w_next_idx   = r_idx + ADDR_W'(1);
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Sequencing state, memory strobe and status flags, all registered off the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= {ADDR_W{1'b0}};
      r_mem_rd   <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_idx    <= w_next_idx;
      r_mem_rd <= (w_next_state == S_FETCH);
      if (w_next_state == S_FETCH) begin
        r_mem_addr <= w_next_idx;
      end
      r_busy <= (w_next_state == S_FETCH) || (w_next_state == S_APPLY) ||
                (w_next_state == S_SETTLE) || (w_next_state == S_CHECK);
      r_done <= (w_next_state == S_DONE);
    end
  end

  // Stimulus/expected capture and settle timer; dut_stim deliberately holds after a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dut_stim   <= {STIM_W{1'b0}};
      r_exp        <= {RESP_W{1'b0}};
      r_settle_cnt <= {SW{1'b0}};
    end else if (r_state == S_APPLY) begin
      r_dut_stim   <= mem_stim;
      r_exp        <= mem_exp;
      r_settle_cnt <= {SW{1'b0}};
    end else if (r_state == S_SETTLE) begin
      r_settle_cnt <= r_settle_cnt + SW'(1);
    end
  end

  // Scoreboard: cleared on every launch, updated once per vector in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score      <= {CNT_W{1'b0}};
      r_fail_count <= {CNT_W{1'b0}};
      r_ff_vld     <= 1'b0;
      r_ff_idx     <= {ADDR_W{1'b0}};
    end else if (w_launch) begin
      r_score      <= {CNT_W{1'b0}};
      r_fail_count <= {CNT_W{1'b0}};
      r_ff_vld     <= 1'b0;
      r_ff_idx     <= {ADDR_W{1'b0}};
    end else if (r_state == S_CHECK) begin
      if (w_pass) begin
        r_score <= r_score + CNT_W'(1);
      end else begin
        r_fail_count <= r_fail_count + CNT_W'(1);
        if (!r_ff_vld) begin
          r_ff_vld <= 1'b1;
          r_ff_idx <= r_idx;
        end
      end
    end
  end

  assign mem_rd         = r_mem_rd;
  assign mem_addr       = r_mem_addr;
  assign dut_stim       = r_dut_stim;
  assign busy           = r_busy;
  assign done           = r_done;
  assign score          = r_score;
  assign fail_count     = r_fail_count;
  assign first_fail_vld = r_ff_vld;
  assign first_fail_idx = r_ff_idx;

endmodule

// File: tb/tb_vector_check_engine.sv
// Bench for vector_check_engine: ALU-style DUT model, vector memories and a cycle-level
// scoreboard derived from per-vector pass/fail, plus lagging-DUT runs at SETTLE=3 and 2.
module tb_vector_check_engine;

  localparam int N = 4;
  localparam int P = 4;   // cycles per vector at SETTLE=1

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_lag;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [67:0] stim_tab [N];
  logic [33:0] exp_lit  [N];
  logic [33:0] exp_mem  [N];

  // ---------------- main instance, SETTLE=1, combinational DUT ----------------
  logic        mem_rd;
  logic [1:0]  mem_addr;
  logic [67:0] mem_stim;
  logic [33:0] mem_exp;
  logic [67:0] dut_stim;
  logic [33:0] dut_resp;
  logic        busy, done, ffv;
  logic [2:0]  score, fail_count;
  logic [1:0]  ffi;

  vector_check_engine #(.STIM_W(68), .RESP_W(34), .NUM_TESTS(N), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_stim(mem_stim), .mem_exp(mem_exp), .dut_stim(dut_stim), .dut_resp(dut_resp),
    .busy(busy), .done(done), .score(score), .fail_count(fail_count),
    .first_fail_vld(ffv), .first_fail_idx(ffi));

  // Reference ALU: {invA, invB, op[1:0], src1, src2} -> {overflow, zero, result}
  function automatic logic [33:0] alu(input logic [67:0] s);
    logic [31:0] a, b, r;
    logic        ov;
    logic [32:0] sum;
    a  = s[67] ? ~s[63:32] : s[63:32];
    b  = s[66] ? ~s[31:0]  : s[31:0];
    ov = 1'b0;
    case (s[65:64])
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: begin
        sum = {1'b0, a} + {1'b0, b} + {32'd0, s[66]};
        r   = sum[31:0];
        ov  = (a[31] == b[31]) && (r[31] != a[31]);
      end
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    return {ov, (r == 32'd0), r};
  endfunction

  assign dut_resp = alu(dut_stim);

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_stim <= stim_tab[mem_addr];
      mem_exp  <= exp_mem[mem_addr];
    end
  end

  // ---------------- lagging-DUT instances (3-cycle response lag) ----------------
  logic        rd3, rd2, busy3, busy2, done3, done2, ffv3, ffv2;
  logic [1:0]  addr3, addr2, ffi3, ffi2;
  logic [67:0] mstim3, mstim2, dstim3, dstim2;
  logic [33:0] mexp3, mexp2, p3a, p3b, p3c, p2a, p2b, p2c;
  logic [2:0]  score3, score2, fail3, fail2;

  vector_check_engine #(.STIM_W(68), .RESP_W(34), .NUM_TESTS(N), .SETTLE(3)) u_lag3 (
    .clk(clk), .rst(rst), .start(start_lag), .mem_rd(rd3), .mem_addr(addr3),
    .mem_stim(mstim3), .mem_exp(mexp3), .dut_stim(dstim3), .dut_resp(p3c),
    .busy(busy3), .done(done3), .score(score3), .fail_count(fail3),
    .first_fail_vld(ffv3), .first_fail_idx(ffi3));

  vector_check_engine #(.STIM_W(68), .RESP_W(34), .NUM_TESTS(N), .SETTLE(2)) u_lag2 (
    .clk(clk), .rst(rst), .start(start_lag), .mem_rd(rd2), .mem_addr(addr2),
    .mem_stim(mstim2), .mem_exp(mexp2), .dut_stim(dstim2), .dut_resp(p2c),
    .busy(busy2), .done(done2), .score(score2), .fail_count(fail2),
    .first_fail_vld(ffv2), .first_fail_idx(ffi2));

  always @(posedge clk) begin
    p3a <= alu(dstim3); p3b <= p3a; p3c <= p3b;
    p2a <= alu(dstim2); p2b <= p2a; p2c <= p2b;
    if (rd3) begin mstim3 <= stim_tab[addr3]; mexp3 <= exp_lit[addr3]; end
    if (rd2) begin mstim2 <= stim_tab[addr2]; mexp2 <= exp_lit[addr2]; end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  bit pass_m [N];
  int n_run;
  int t_end;
  int t_run;
  bit armed = 1'b0;

  // Per-vector verdicts decide how many vectors run and when the run ends.
  task automatic compute_model();
    for (int i = 0; i < N; i++) pass_m[i] = (alu(stim_tab[i]) === exp_mem[i]);
    n_run = N;
`ifdef VEC_CHECK_STOP_ON_FAIL_EN
    for (int i = 0; i < N; i++) begin
      if (!pass_m[i]) begin
        n_run = i + 1;
        break;
      end
    end
`endif
    t_end = n_run * P;
  endtask

  // Expected outputs t cycles after the edge that sampled start.
  task automatic check_cycle(input int t);
    int checked, sc, fc, fi;
    bit fv;
    checked = t / P;
    if (checked > n_run) checked = n_run;
    sc = 0; fc = 0; fi = 0; fv = 1'b0;
    for (int i = 0; i < checked; i++) begin
      if (pass_m[i]) sc++;
      else begin
        if (!fv) begin fv = 1'b1; fi = i; end
        fc++;
      end
    end
    chk("busy", busy, (t < t_end));
    chk("done", done, (t >= t_end));
    chk("score", score, sc);
    chk("fail_count", fail_count, fc);
    chk("first_fail_vld", ffv, fv);
    chk("first_fail_idx", ffi, fi);
    chk("mem_rd", mem_rd, (t < t_end) && (t % P == 0));
    if ((t < t_end) && (t % P == 0)) chk("mem_addr", mem_addr, t / P);
    if ((t < t_end) && (t % P >= 2)) chk("dut_stim", dut_stim, stim_tab[t / P]);
    if (t >= t_end) chk("dut_stim_hold", dut_stim, stim_tab[n_run - 1]);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check_cycle(t_run);
      t_run++;
    end
  end

  // Launch a run; optionally pulse start mid-run, or stop watching after abort_at cycles.
  task automatic do_run(input int pulse_at, input int abort_at);
    int lim;
    compute_model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    t_run = 0;
    armed = 1'b1;
    lim = (abort_at >= 0) ? abort_at : t_end + 3;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      start = (k == pulse_at) ? 1'b1 : 1'b0;
    end
    #1;
    armed = 1'b0;
    start = 1'b0;
  endtask

  task automatic load_good();
    for (int i = 0; i < N; i++) exp_mem[i] = exp_lit[i];
  endtask

  initial begin
    stim_tab[0] = {1'b0, 1'b0, 2'b10, 32'd5, 32'd3};                  // 5+3
    stim_tab[1] = {1'b0, 1'b0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00};  // AND
    stim_tab[2] = {1'b0, 1'b1, 2'b10, 32'd7, 32'd7};                  // 7-7
    stim_tab[3] = {1'b0, 1'b0, 2'b10, 32'h7FFF_FFFF, 32'd1};          // overflow
    exp_lit[0]  = 34'h0_0000_0008;
    exp_lit[1]  = 34'h0_F000_F000;
    exp_lit[2]  = 34'h1_0000_0000;
    exp_lit[3]  = 34'h2_8000_0000;
    load_good();
    rst = 1'b1; start = 1'b0; start_lag = 1'b0;

    for (int i = 0; i < N; i++) chk("alu_pin", alu(stim_tab[i]), exp_lit[i]);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_score", score, 3'd0);
    chk("rst_fail", fail_count, 3'd0);
    chk("rst_ffv", ffv, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 2'd0);
    chk("rst_dut_stim", dut_stim, 68'd0);

    // all vectors correct; done 16 cycles after the start edge
    do_run(-1, -1);
    chk("t2_score", score, 3'd4);
    chk("t2_fail", fail_count, 3'd0);
    chk("t2_ffv", ffv, 1'b0);

    // vector 2 expected zero flag wrong
    exp_mem[2] = 34'h0_0000_0000;
    do_run(-1, -1);
`ifdef VEC_CHECK_STOP_ON_FAIL_EN
    chk("t3_score", score, 3'd2);
`else
    chk("t3_score", score, 3'd3);
`endif
    chk("t3_fail", fail_count, 3'd1);
    chk("t3_ffv", ffv, 1'b1);
    chk("t3_ffi", ffi, 2'd2);

    // vectors 1 and 3 fail
    load_good();
    exp_mem[1] = 34'h0_F000_F001;
    exp_mem[3] = 34'h0_8000_0000;
    do_run(-1, -1);
    chk("t4_ffi", ffi, 2'd1);
`ifdef VEC_CHECK_STOP_ON_FAIL_EN
    chk("t4_score", score, 3'd1);
    chk("t4_fail", fail_count, 3'd1);
`else
    chk("t4_score", score, 3'd2);
    chk("t4_fail", fail_count, 3'd2);
`endif

    // start pulse while busy is ignored; restart from DONE clears and repeats
    load_good();
    exp_mem[0] = 34'h0_0000_0009;
    do_run(5, -1);
    load_good();
    do_run(-1, -1);
    chk("t5_score", score, 3'd4);
    do_run(-1, -1);
    chk("t5_rerun_score", score, 3'd4);

    // reset during SETTLE of vector 2
    do_run(-1, 11);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_busy", busy, 1'b0);
    chk("t1_done", done, 1'b0);
    chk("t1_score", score, 3'd0);
    chk("t1_dut_stim", dut_stim, 68'd0);
    chk("t1_mem_rd", mem_rd, 1'b0);
    rst = 1'b0;

    // lagging DUT: SETTLE=3 passes, SETTLE=2 fails
    repeat (4) @(negedge clk);
    start_lag = 1'b1;
    @(negedge clk);
    start_lag = 1'b0;
    repeat (4 * 6 + 2) @(negedge clk);
    chk("t6_done3", done3, 1'b1);
    chk("t6_score3", score3, 3'd4);
    chk("t6_fail3", fail3, 3'd0);
    chk("t6_done2", done2, 1'b1);
    chk("t6_score2", score2, 3'd0);
    chk("t6_ffv2", ffv2, 1'b1);
    chk("t6_ffi2", ffi2, 2'd0);
`ifdef VEC_CHECK_STOP_ON_FAIL_EN
    chk("t6_fail2", fail2, 3'd1);
`else
    chk("t6_fail2", fail2, 3'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
